// File: rtl/imem_responder_if.sv
// Fetch-side bus between the PC logic (master) and the instruction memory responder (slave).
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipe feeding an in-order show-ahead response FIFO.
// mem holds the read-only code.txt image, placed there by the image loader before reset is released.
module imem_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WORDS   = 4096,
    parameter logic [31:0] BASE    = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    imem_responder_if.slave   bus
);

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PN = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    logic [31:0] mem [WORDS] = '{default: '0};

    logic [CW-1:0] count;
    logic [PN-1:0] pv_q;
    entry_t        pe_q [PN];
    entry_t        fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fcnt;

    logic          accept;
    logic          pop;
    logic          push;
    entry_t        in_ent;
    entry_t        push_ent;
    entry_t        head;
    logic [31:0]   off;
    logic [31:0]   woff;
    logic          in_err;

    // Address decode and memory read for the request being accepted
    always_comb begin
        off          = bus.req_addr - BASE;
        woff         = off >> 2;
        in_err       = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE) ||
                       (woff >= 32'(WORDS));
        in_ent.addr  = bus.req_addr;
        in_ent.err   = in_err;
        in_ent.instr = in_err ? 32'h0 : mem[woff[AW-1:0]];
    end

    assign bus.req_ready  = (count < CW'(DEPTH)) && !bus.flush && reset;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (fcnt != '0);
    assign pop            = bus.resp_valid && bus.resp_ready && !bus.flush;

    // The FIFO write is the final latency stage, so only LATENCY-1 registers sit in front of it
    generate
        if (LATENCY == 1) begin : g_direct
            assign push     = accept;
            assign push_ent = in_ent;
        end else begin : g_pipe
            assign push     = pv_q[PN-1];
            assign push_ent = pe_q[PN-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int unsigned k = 1; k < PN; k++) begin
                pv_q[k] <= pv_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pe_q[0] <= in_ent;
        for (int unsigned k = 1; k < PN; k++) begin
            pe_q[k] <= pe_q[k-1];
        end
    end

    // Outstanding count bounds FIFO occupancy, so push never finds it full
    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            count <= count + CW'(accept) - CW'(pop);
            fcnt  <= fcnt + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !bus.flush && push) begin
            fifo[wr_ptr] <= push_ent;
        end
    end

    // Head is masked when empty so no stale entry is ever visible
    assign head           = fifo[rd_ptr];
    assign bus.resp_instr = bus.resp_valid ? head.instr : 32'h0;
    assign bus.resp_addr  = bus.resp_valid ? head.addr  : 32'h0;
    assign bus.resp_err   = bus.resp_valid ? head.err   : 1'b0;

endmodule
